ppu_bg_fetcher: RTL and testbench
=================================

Name: ppu_bg_fetcher

Overview:
Background tile fetcher for the PPU render path. On a line-start strobe it walks one scanline of the 32x32 background map and fetches, per tile, the map entry and the low/high tile-data bytes from VRAM. It serialises the result into 2-bit colour indices and pushes them through a valid/ready stream into the PPU pixel/palette stage. The PPU mode/timing logic triggers it, and VRAM is the shared 8 KB video RAM.

Parameters:
LINE_PIXELS, 160, pixels emitted per scanline.
VRAM_LAT, 1, cycles from vram_rd assertion to vram_data valid (1..3).

Ports:
Clk  in  1  system clock; all state is updated on its rising edge.
reset  in  1  asynchronous, active-high reset.
line_start  in  1  one-cycle strobe that begins fetching a scanline.
line_y  in  8  current LY (0..143).
scroll_x  in  8  SCX.
scroll_y  in  8  SCY.
bg_map_sel  in  1  LCDC.3: 0 -> map base 0x9800, 1 -> map base 0x9C00.
tile_data_sel  in  1  LCDC.4: 1 -> unsigned tiles at 0x8000, 0 -> signed tiles around 0x9000.
vram_addr  out  16  CPU-space VRAM byte address.
vram_rd  out  1  read request, asserted for one cycle per byte.
vram_data  in  8  read data, valid VRAM_LAT cycles after vram_rd.
pix_valid  out  1  pix_color is valid.
pix_ready  in  1  downstream accepts a pixel.
pix_color  out  2  colour index {hi_bit, lo_bit}.
busy  out  1  a line is in progress.
line_done  out  1  one-cycle pulse after the last pixel is accepted.

Behaviour:
- Reset values: vram_addr=0, vram_rd=0, pix_valid=0, pix_color=0, busy=0, line_done=0. State goes to IDLE and all counters clear.
- States:
  - IDLE -> MAP_RD on line_start.
  - MAP_RD -> MAP_WAIT.
  - MAP_WAIT, held for VRAM_LAT cycles -> LO_RD.
  - LO_RD -> LO_WAIT -> HI_RD -> HI_WAIT.
  - HI_WAIT -> PUSH.
  - In PUSH, after the 8th shifter pixel is handled: go to MAP_RD if pixels remain, otherwise to DONE.
  - DONE -> IDLE, with line_done=1 for that one cycle.
- Latching on line_start: latch scroll_x, scroll_y, line_y and the select bits. Later input changes do not affect the line in progress.
- Background coordinates: bg_y = line_y + scroll_y, mod 256, giving tile_row = bg_y[7:3] and fine_y = bg_y[2:0].
- Tile column: starts at scroll_x[7:3] and increments by 1 per tile, mod 32 (wraps 31 -> 0).
- Map address: map_base + tile_row*32 + tile_col.
- Tile data address:
  - tile_data_sel=1: 0x8000 + tile*16 + fine_y*2.
  - tile_data_sel=0: 0x9000 + sext(tile)*16 + fine_y*2.
  - The high byte is at the tile data address + 1.
- Pixel ordering: pixel i of a tile (i=0 leftmost) = {hi[7-i], lo[7-i]}, held in an 8-entry shifter.
- Fine scroll: for the first tile only, the first scroll_x[2:0] pixels are discarded internally at one per cycle. They never assert pix_valid.
- Stream rules: a transfer occurs when pix_valid && pix_ready. pix_valid and pix_color are held stable while pix_ready=0. Back-to-back transfers run at 1 pixel/cycle inside PUSH.
- No overlap: the next tile's fetch starts only after the shifter empties.
- Pixel count: a counter of accepted pixels stops the line at exactly LINE_PIXELS. Leftover shifter pixels are dropped.
- busy=1 in every state except IDLE.
- Restart: line_start while busy aborts the current line, drops pix_valid the next cycle, relatches inputs and restarts at MAP_RD. line_done is not pulsed for the aborted line.
- Reset mid-line: returns to the reset values immediately.
- vram_rd is high only in the *_RD states. vram_addr holds its last value elsewhere.

Decomposition:
- Package ppu_pkg:
  - fetch state enum;
  - constants MAP_BASE_0=16'h9800, MAP_BASE_1=16'h9C00, TILE_BASE_U=16'h8000, TILE_BASE_S=16'h9000.
- Sub-module bg_pixel_shifter: loads lo/hi bytes plus a discard count, shifts on transfer or discard, and reports empty.

Test Plan:
1. SCX=0, SCY=0, LY=0, bg_map_sel=0, tile_data_sel=1, map[0x9800]=0x01, tile1 bytes 0x8010=0xF0 / 0x8011=0xCC, pix_ready=1 -> first reads at 0x9800, 0x8010, 0x8011; first 8 colours 3,3,1,1,2,2,0,0.
2. SCX=5 with the pattern from test 1 -> first emitted pixel is original pixel 5; exactly 160 pixels emitted; line_done pulses once.
3. SCX=0xF8, SCY=0xFC, LY=6 -> bg_y=2, tile_row=0, first map read 0x981F, second 0x9800 (column wrap).
4. tile_data_sel=0, map entry 0x80, fine_y=0 -> low-byte read at 0x8800, high at 0x8801.
5. pix_ready toggled 1,0,0,1 -> pix_color is held across stalls; no pixel is lost or duplicated; total 160 transfers.
6. line_start reasserted at pixel 40, then reset pulsed mid-fetch -> restart re-reads the map; reset forces all outputs to 0 within the same cycle.

Source files
------------

// File: rtl/ppu_pkg.sv
// ppu_pkg: fetch-state encoding, VRAM base addresses and address helpers for the background fetcher
package ppu_pkg;
  typedef logic [3:0] fetch_state_t;
  localparam fetch_state_t S_IDLE     = 4'd0;
  localparam fetch_state_t S_MAP_RD   = 4'd1;
  localparam fetch_state_t S_MAP_WAIT = 4'd2;
  localparam fetch_state_t S_LO_RD    = 4'd3;
  localparam fetch_state_t S_LO_WAIT  = 4'd4;
  localparam fetch_state_t S_HI_RD    = 4'd5;
  localparam fetch_state_t S_HI_WAIT  = 4'd6;
  localparam fetch_state_t S_PUSH     = 4'd7;
  localparam fetch_state_t S_DONE     = 4'd8;
  localparam logic [15:0] MAP_BASE_0  = 16'h9800;
  localparam logic [15:0] MAP_BASE_1  = 16'h9C00;
  localparam logic [15:0] TILE_BASE_U = 16'h8000;
  localparam logic [15:0] TILE_BASE_S = 16'h9000;
  function automatic logic [15:0] map_addr(input logic sel, input logic [4:0] row, input logic [4:0] col);
    return (sel ? MAP_BASE_1 : MAP_BASE_0) + {6'd0, row, col};
  endfunction
  function automatic logic [15:0] tile_addr(input logic sel, input logic [7:0] tile, input logic [2:0] fine);
    return sel ? TILE_BASE_U + {4'd0, tile, 4'd0} + {12'd0, fine, 1'b0}
               : TILE_BASE_S + {{4{tile[7]}}, tile, 4'd0} + {12'd0, fine, 1'b0};
  endfunction
endpackage

// File: rtl/ppu_bg_fetcher_shifter.sv
// bg_pixel_shifter: holds one tile row, drops fine-scroll pixels, then shifts out on each transfer
module bg_pixel_shifter (
  input  logic       Clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] lo_in,
  input  logic [7:0] hi_in,
  input  logic [2:0] disc_in,
  input  logic       shift,
  output logic       empty,
  output logic       discarding,
  output logic       last,
  output logic [1:0] color
);
  logic [7:0] lo_q, lo_d, hi_q, hi_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] disc_q, disc_d;
  logic step;
  assign empty = cnt_q == 4'd0;
  assign discarding = !empty && disc_q != 3'd0;
  assign last = cnt_q == 4'd1;
  assign color = {hi_q[7], lo_q[7]};
  assign step = discarding || (shift && !empty);
  // load a fresh tile row, or drop the leftmost pixel when it is discarded or accepted
  always_comb begin
    lo_d = load ? lo_in : step ? {lo_q[6:0], 1'b0} : lo_q;
    hi_d = load ? hi_in : step ? {hi_q[6:0], 1'b0} : hi_q;
    cnt_d = load ? 4'd8 : step ? cnt_q - 4'd1 : cnt_q;
    disc_d = load ? disc_in : discarding ? disc_q - 3'd1 : disc_q;
  end
  // shifter registers
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      lo_q <= '0;
      hi_q <= '0;
      cnt_q <= '0;
      disc_q <= '0;
    end else begin
      lo_q <= lo_d;
      hi_q <= hi_d;
      cnt_q <= cnt_d;
      disc_q <= disc_d;
    end
  end
endmodule

// File: rtl/ppu_bg_fetcher.sv
// ppu_bg_fetcher: walks one scanline of the background map, fetching tiles from VRAM into a 2-bit pixel stream
module ppu_bg_fetcher
  import ppu_pkg::*;
#(
  parameter int LINE_PIXELS = 160,
  parameter int VRAM_LAT = 1
) (
  input  logic        Clk,
  input  logic        reset,
  input  logic        line_start,
  input  logic [7:0]  line_y,
  input  logic [7:0]  scroll_x,
  input  logic [7:0]  scroll_y,
  input  logic        bg_map_sel,
  input  logic        tile_data_sel,
  output logic [15:0] vram_addr,
  output logic        vram_rd,
  input  logic [7:0]  vram_data,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [1:0]  pix_color,
  output logic        busy,
  output logic        line_done
);
  fetch_state_t state_q, state_d;
  logic [1:0] wcnt_q, wcnt_d;
  logic [15:0] addr_q, addr_d;
  logic [4:0] col_q, col_d, row_q, row_d;
  logic [2:0] fine_y_q, fine_y_d, fine_x_q, fine_x_d;
  logic map_sel_q, map_sel_d, data_sel_q, data_sel_d, first_q, first_d;
  logic [7:0] lo_q, lo_d, pcnt_q, pcnt_d, bg_y;
  logic load, empty, discarding, last, xfer, handled, wait_end;
  logic [1:0] color;
  assign bg_y = line_y + scroll_y;
  assign wait_end = wcnt_q == 2'(VRAM_LAT - 1);
  assign pix_valid = state_q == S_PUSH && !empty && !discarding;
  assign pix_color = pix_valid ? color : 2'b00;
  assign xfer = pix_valid && pix_ready;
  assign handled = state_q == S_PUSH && (xfer || discarding);
  assign vram_rd = state_q == S_MAP_RD || state_q == S_LO_RD || state_q == S_HI_RD;
  assign vram_addr = addr_q;
  assign busy = state_q != S_IDLE;
  assign line_done = state_q == S_DONE;
  bg_pixel_shifter u_shifter (
    .Clk(Clk),
    .reset(reset),
    .load(load),
    .lo_in(lo_q),
    .hi_in(vram_data),
    .disc_in(first_q ? fine_x_q : 3'd0),
    .shift(xfer),
    .empty(empty),
    .discarding(discarding),
    .last(last),
    .color(color)
  );
  // fetch sequencing; a line_start always wins and relatches the line parameters
  always_comb begin
    state_d = state_q;
    wcnt_d = wcnt_q;
    addr_d = addr_q;
    col_d = col_q;
    row_d = row_q;
    fine_y_d = fine_y_q;
    fine_x_d = fine_x_q;
    map_sel_d = map_sel_q;
    data_sel_d = data_sel_q;
    first_d = first_q;
    lo_d = lo_q;
    pcnt_d = pcnt_q;
    load = 1'b0;
    case (state_q)
      S_MAP_RD: begin
        state_d = S_MAP_WAIT;
        wcnt_d = '0;
      end
      S_MAP_WAIT: begin
        wcnt_d = wcnt_q + 2'd1;
        if (wait_end) begin
          state_d = S_LO_RD;
          addr_d = tile_addr(data_sel_q, vram_data, fine_y_q);
        end
      end
      S_LO_RD: begin
        state_d = S_LO_WAIT;
        wcnt_d = '0;
      end
      S_LO_WAIT: begin
        wcnt_d = wcnt_q + 2'd1;
        if (wait_end) begin
          state_d = S_HI_RD;
          lo_d = vram_data;
          addr_d = addr_q + 16'd1;
        end
      end
      S_HI_RD: begin
        state_d = S_HI_WAIT;
        wcnt_d = '0;
      end
      S_HI_WAIT: begin
        wcnt_d = wcnt_q + 2'd1;
        if (wait_end) begin
          state_d = S_PUSH;
          load = 1'b1;
        end
      end
      S_PUSH: begin
        pcnt_d = xfer ? pcnt_q + 8'd1 : pcnt_q;
        if (xfer && pcnt_q == 8'(LINE_PIXELS - 1)) state_d = S_DONE;
        else if (handled && last) begin
          state_d = S_MAP_RD;
          col_d = col_q + 5'd1;
          addr_d = map_addr(map_sel_q, row_q, col_q + 5'd1);
          first_d = 1'b0;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (line_start) begin
      state_d = S_MAP_RD;
      row_d = bg_y[7:3];
      fine_y_d = bg_y[2:0];
      col_d = scroll_x[7:3];
      fine_x_d = scroll_x[2:0];
      map_sel_d = bg_map_sel;
      data_sel_d = tile_data_sel;
      addr_d = map_addr(bg_map_sel, bg_y[7:3], scroll_x[7:3]);
      first_d = 1'b1;
      pcnt_d = '0;
    end
  end
  // fetcher state registers
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      wcnt_q <= '0;
      addr_q <= '0;
      col_q <= '0;
      row_q <= '0;
      fine_y_q <= '0;
      fine_x_q <= '0;
      map_sel_q <= 1'b0;
      data_sel_q <= 1'b0;
      first_q <= 1'b0;
      lo_q <= '0;
      pcnt_q <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q <= wcnt_d;
      addr_q <= addr_d;
      col_q <= col_d;
      row_q <= row_d;
      fine_y_q <= fine_y_d;
      fine_x_q <= fine_x_d;
      map_sel_q <= map_sel_d;
      data_sel_q <= data_sel_d;
      first_q <= first_d;
      lo_q <= lo_d;
      pcnt_q <= pcnt_d;
    end
  end
endmodule

// File: tb/tb_ppu_bg_fetcher.sv
// tb_ppu_bg_fetcher: directed scanline scenarios against a VRAM model and a background pixel reference
module tb_ppu_bg_fetcher;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic line_start = 1'b0;
  logic [7:0] line_y = '0, scroll_x = '0, scroll_y = '0;
  logic bg_map_sel = 1'b0, tile_data_sel = 1'b1;
  logic [15:0] vram_addr;
  logic vram_rd;
  logic [7:0] vram_data = '0;
  logic pix_valid, pix_ready = 1'b1, busy, line_done;
  logic [1:0] pix_color;
  logic [7:0] mem [0:8191];
  logic [15:0] rd_q[$];
  logic [1:0] px_q[$];
  int done_cnt = 0, hold_bad = 0, checks = 0, failures = 0;
  logic prev_stall = 1'b0;
  logic [1:0] prev_col = '0;
  logic cur_ms, cur_ds;
  logic [7:0] cur_ly, cur_sx, cur_sy;

  ppu_bg_fetcher #(.LINE_PIXELS(160), .VRAM_LAT(1)) dut (
    .Clk(clk), .reset(reset), .line_start(line_start), .line_y(line_y),
    .scroll_x(scroll_x), .scroll_y(scroll_y), .bg_map_sel(bg_map_sel),
    .tile_data_sel(tile_data_sel), .vram_addr(vram_addr), .vram_rd(vram_rd),
    .vram_data(vram_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_color(pix_color), .busy(busy), .line_done(line_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (vram_rd) vram_data <= mem[vram_addr[12:0]];

  always @(negedge clk) begin
    if (reset) prev_stall = 1'b0;
    else begin
      if (vram_rd) rd_q.push_back(vram_addr);
      if (pix_valid && pix_ready) px_q.push_back(pix_color);
      if (line_done) done_cnt++;
      if (prev_stall && !(pix_valid && pix_color == prev_col)) hold_bad++;
      prev_stall = pix_valid && !pix_ready;
      prev_col = pix_color;
    end
  end

  function automatic logic [1:0] exp_pix(input int n);
    int by, bx, t, st, ma, ta, k;
    logic [7:0] lo, hi;
    by = (int'(cur_ly) + int'(cur_sy)) % 256;
    bx = (int'(cur_sx) + n) % 256;
    ma = (cur_ms ? 'h9C00 : 'h9800) + (by / 8) * 32 + bx / 8;
    t = int'(mem[ma - 'h8000]);
    st = t >= 128 ? t - 256 : t;
    ta = cur_ds ? 'h8000 + t * 16 + (by % 8) * 2 : 'h9000 + st * 16 + (by % 8) * 2;
    lo = mem[ta - 'h8000];
    hi = mem[ta - 'h8000 + 1];
    k = 7 - bx % 8;
    return {hi[k], lo[k]};
  endfunction

  task automatic start_line(input logic ms, input logic ds, input logic [7:0] ly, input logic [7:0] sx, input logic [7:0] sy);
    cur_ms = ms; cur_ds = ds; cur_ly = ly; cur_sx = sx; cur_sy = sy;
    @(posedge clk); #1;
    bg_map_sel = ms; tile_data_sel = ds; line_y = ly; scroll_x = sx; scroll_y = sy;
    rd_q.delete(); px_q.delete(); hold_bad = 0;
    line_start = 1'b1;
    @(posedge clk); #1;
    line_start = 1'b0;
    bg_map_sel = ~ms; tile_data_sel = ~ds; line_y = ly + 8'd50; scroll_x = ~sx; scroll_y = sy + 8'd99;
  endtask

  task automatic wait_done(input int d0, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (done_cnt != d0) begin ok = 1'b1; break; end
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++; if (vram_addr !== 16'h0) begin failures++; $display("FAIL reset_addr got=%h want=0000", vram_addr); end
    checks++; if (vram_rd !== 1'b0) begin failures++; $display("FAIL reset_rd got=%b want=0", vram_rd); end
    checks++; if (pix_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", pix_valid); end
    checks++; if (pix_color !== 2'b0) begin failures++; $display("FAIL reset_color got=%0d want=0", pix_color); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (line_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", line_done); end
    @(posedge clk); #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%b want=0", busy); end
  endtask

  task automatic test_basic;
    int d0;
    bit ok;
    logic [1:0] want [8] = '{2'd3, 2'd3, 2'd1, 2'd1, 2'd2, 2'd2, 2'd0, 2'd0};
    d0 = done_cnt;
    start_line(1'b0, 1'b1, 8'd0, 8'd0, 8'd0);
    wait_done(d0, ok);
    checks++; if (!ok) begin failures++; $display("FAIL basic_timeout got=no line_done want=line_done"); end
    checks++; if (rd_q.size() < 3 || rd_q[0] !== 16'h9800 || rd_q[1] !== 16'h8010 || rd_q[2] !== 16'h8011) begin
      failures++; $display("FAIL basic_reads got=%p want=9800,8010,8011...", rd_q[0:2]); end
    for (int i = 0; i < 8 && i < px_q.size(); i++) begin
      checks++; if (px_q[i] !== want[i]) begin failures++; $display("FAIL basic_pix%0d got=%0d want=%0d", i, px_q[i], want[i]); end
    end
    checks++; if (px_q.size() != 160) begin failures++; $display("FAIL basic_count got=%0d want=160", px_q.size()); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_idle got=%b want=0", busy); end
  endtask

  task automatic test_fine_scroll;
    int d0;
    bit ok;
    d0 = done_cnt;
    start_line(1'b0, 1'b1, 8'd0, 8'd5, 8'd0);
    wait_done(d0, ok);
    checks++; if (!ok) begin failures++; $display("FAIL fine_timeout got=no line_done want=line_done"); end
    checks++; if (px_q.size() != 160) begin failures++; $display("FAIL fine_count got=%0d want=160", px_q.size()); end
    checks++; if (px_q.size() == 0 || px_q[0] !== 2'd2) begin failures++; $display("FAIL fine_first got=%p want=2", px_q[0:0]); end
    for (int i = 0; i < px_q.size() && i < 160; i++) begin
      checks++; if (px_q[i] !== exp_pix(i)) begin failures++; $display("FAIL fine_pix%0d got=%0d want=%0d", i, px_q[i], exp_pix(i)); end
    end
    checks++; if (done_cnt - d0 != 1) begin failures++; $display("FAIL fine_done_pulses got=%0d want=1", done_cnt - d0); end
  endtask

  task automatic test_wrap;
    int d0;
    bit ok;
    d0 = done_cnt;
    start_line(1'b0, 1'b1, 8'd6, 8'hF8, 8'hFC);
    wait_done(d0, ok);
    checks++; if (!ok) begin failures++; $display("FAIL wrap_timeout got=no line_done want=line_done"); end
    checks++; if (rd_q.size() < 4 || rd_q[0] !== 16'h981F || rd_q[1] !== 16'h8204 || rd_q[3] !== 16'h9800) begin
      failures++; $display("FAIL wrap_reads got=%p want=981F,8204,8205,9800", rd_q[0:3]); end
    checks++; if (px_q.size() != 160) begin failures++; $display("FAIL wrap_count got=%0d want=160", px_q.size()); end
    for (int i = 0; i < px_q.size() && i < 160; i++) begin
      checks++; if (px_q[i] !== exp_pix(i)) begin failures++; $display("FAIL wrap_pix%0d got=%0d want=%0d", i, px_q[i], exp_pix(i)); end
    end
  endtask

  task automatic test_signed;
    int d0;
    bit ok;
    d0 = done_cnt;
    start_line(1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
    wait_done(d0, ok);
    checks++; if (!ok) begin failures++; $display("FAIL signed_timeout got=no line_done want=line_done"); end
    checks++; if (rd_q.size() < 3 || rd_q[0] !== 16'h9C00 || rd_q[1] !== 16'h8800 || rd_q[2] !== 16'h8801) begin
      failures++; $display("FAIL signed_reads got=%p want=9C00,8800,8801", rd_q[0:2]); end
    for (int i = 0; i < px_q.size() && i < 160; i++) begin
      checks++; if (px_q[i] !== exp_pix(i)) begin failures++; $display("FAIL signed_pix%0d got=%0d want=%0d", i, px_q[i], exp_pix(i)); end
    end
  endtask

  task automatic test_stall;
    int d0;
    bit ok;
    logic [3:0] pat;
    pat = 4'b1001;
    d0 = done_cnt;
    start_line(1'b0, 1'b0, 8'd77, 8'd3, 8'd20);
    ok = 1'b0;
    for (int k = 0; k < 6000; k++) begin
      pix_ready = pat[k % 4];
      @(posedge clk); #1;
      if (done_cnt != d0) begin ok = 1'b1; break; end
    end
    pix_ready = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (!ok) begin failures++; $display("FAIL stall_timeout got=no line_done want=line_done"); end
    checks++; if (px_q.size() != 160) begin failures++; $display("FAIL stall_count got=%0d want=160", px_q.size()); end
    checks++; if (hold_bad != 0) begin failures++; $display("FAIL stall_hold got=%0d unstable stalls want=0", hold_bad); end
    for (int i = 0; i < px_q.size() && i < 160; i++) begin
      checks++; if (px_q[i] !== exp_pix(i)) begin failures++; $display("FAIL stall_pix%0d got=%0d want=%0d", i, px_q[i], exp_pix(i)); end
    end
  endtask

  task automatic test_restart_reset;
    int d0, rcount;
    bit ok;
    d0 = done_cnt;
    start_line(1'b0, 1'b1, 8'd0, 8'd0, 8'd0);
    for (int i = 0; i < 2000 && px_q.size() < 40; i++) @(negedge clk);
    checks++; if (px_q.size() < 40) begin failures++; $display("FAIL restart_reach40 got=%0d want>=40", px_q.size()); end
    @(posedge clk); #1;
    bg_map_sel = 1'b0; tile_data_sel = 1'b1; line_y = 8'd8; scroll_x = 8'h10; scroll_y = 8'd0;
    line_start = 1'b1;
    rcount = rd_q.size();
    @(posedge clk); #1;
    line_start = 1'b0;
    checks++; if (pix_valid !== 1'b0) begin failures++; $display("FAIL restart_valid got=%b want=0", pix_valid); end
    checks++; if (vram_rd !== 1'b1 || vram_addr !== 16'h9822) begin
      failures++; $display("FAIL restart_map got=rd%b/%h want=rd1/9822", vram_rd, vram_addr); end
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rd_q.size() >= rcount + 5) begin ok = 1'b1; break; end
    end
    checks++; if (!ok || rd_q[rcount] !== 16'h9822) begin failures++; $display("FAIL restart_reread got=%0d reads want=map 9822 re-read", rd_q.size() - rcount); end
    #2 reset = 1'b1;
    #1;
    checks++; if (vram_rd !== 1'b0 || vram_addr !== 16'h0) begin failures++; $display("FAIL midreset_vram got=rd%b/%h want=rd0/0000", vram_rd, vram_addr); end
    checks++; if (pix_valid !== 1'b0 || pix_color !== 2'b0) begin failures++; $display("FAIL midreset_pix got=%b/%0d want=0/0", pix_valid, pix_color); end
    checks++; if (busy !== 1'b0 || line_done !== 1'b0) begin failures++; $display("FAIL midreset_status got=%b/%b want=0/0", busy, line_done); end
    @(posedge clk); #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (done_cnt != d0) begin failures++; $display("FAIL restart_no_done got=%0d pulses want=0", done_cnt - d0); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL postreset_busy got=%b want=0", busy); end
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
    for (int i = 0; i < 'h1800; i++) mem[i] = 8'(i * 37 + 11);
    mem['h10] = 8'hF0; mem['h11] = 8'hCC;
    mem['h800] = 8'hAA; mem['h801] = 8'h0F;
    for (int i = 0; i < 1024; i++) begin
      mem['h1800 + i] = 8'(i + 1);
      mem['h1C00 + i] = 8'(8'h80 + i);
    end
    test_reset;
    test_basic;
    test_fine_scroll;
    test_wrap;
    test_signed;
    test_stall;
    test_restart_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
